// File: rtl/f1_light_seq_if.sv
// Handshake bundle for the F1 start-light sequencer.
// The master drives the controls; the slave returns the bar and status.
interface f1_light_seq_if #(
    parameter int NUM_LIGHTS = 8,
    parameter int DIV_WIDTH  = 16
);
    logic                  en;
    logic                  trigger;
    logic [DIV_WIDTH-1:0]  N;
    logic [NUM_LIGHTS-1:0] data_out;
    logic                  busy;
    logic                  lights_out;

    modport master (
        output en, trigger, N,
        input  data_out, busy, lights_out
    );

    modport slave (
        input  en, trigger, N,
        output data_out, busy, lights_out
    );
endinterface

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: prescaler, light FSM and hold timer.
// Define RANDOM_DELAY_EN to take the hold length from a 7-bit LFSR.
module f1_light_seq #(
    parameter int NUM_LIGHTS = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int HOLD_TICKS = 4
) (
    input logic clk,
    input logic rst,
    f1_light_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [6:0]            hold_cnt;
    logic [6:0]            hold_load;
    logic [NUM_LIGHTS-1:0] lights;
    logic                  pulse;
    logic                  busy;
    logic                  accept;
    logic                  tick;
    logic                  fill_tick;
    logic                  full_tick;
    logic                  hold_tick;
    logic                  done_tick;

    // State register; en=0 freezes the sequence
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (bus.en)
            state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = FILL;
            FILL: if (full_tick) state_nxt = HOLD;
            HOLD: if (done_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state strobes and busy decode
    always_comb begin
        busy      = 1'b0;
        accept    = 1'b0;
        tick      = 1'b0;
        fill_tick = 1'b0;
        full_tick = 1'b0;
        hold_tick = 1'b0;
        done_tick = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                accept = bus.en && bus.trigger;
            end
            (state == FILL): begin
                busy      = 1'b1;
                tick      = bus.en && (cnt == '0);
                fill_tick = tick;
                full_tick = tick && lights[NUM_LIGHTS-2];
            end
            (state == HOLD): begin
                busy      = 1'b1;
                tick      = bus.en && (cnt == '0);
                hold_tick = tick;
                done_tick = tick && (hold_cnt == 7'd1);
            end
            default: ;
        endcase
    end

    // Prescaler: N is only sampled on load, so edits land next period
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (accept || tick)
            cnt <= bus.N;
        else if (bus.en && busy)
            cnt <= cnt - 1'b1;
    end

    // Light bar fills LSB-first and clears at the end of the hold
    always_ff @(posedge clk) begin
        if (rst)
            lights <= '0;
        else if (done_tick)
            lights <= '0;
        else if (fill_tick)
            lights <= {lights[NUM_LIGHTS-2:0], 1'b1};
    end

    // Hold counter is armed on the tick that fills the bar
    always_ff @(posedge clk) begin
        if (rst)
            hold_cnt <= '0;
        else if (full_tick)
            hold_cnt <= hold_load;
        else if (hold_tick)
            hold_cnt <= hold_cnt - 7'd1;
    end

    // One-cycle lights-out strobe, registered with the clear
    always_ff @(posedge clk) begin
        if (rst)
            pulse <= 1'b0;
        else
            pulse <= done_tick;
    end

`ifdef RANDOM_DELAY_EN
    logic [6:0] lfsr;

    // x^7+x^6+1 LFSR, free-running on enabled cycles, never zero
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 7'h01;
        else if (bus.en)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign hold_load = lfsr;
`else
    assign hold_load = 7'(HOLD_TICKS);
`endif

    assign bus.data_out   = lights;
    assign bus.busy       = busy;
    assign bus.lights_out = pulse & bus.en;
endmodule

// File: tb/tb_f1_light_seq.sv
// Self-checking bench for f1_light_seq with a cycle-count model.
// Covers fill, prescale, stall, abort, hold length and widths 2/16.
module tb_f1_light_seq;
    localparam int NL = 8;
    localparam int DW = 16;
    localparam int HT = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_on;

    f1_light_seq_if #(.NUM_LIGHTS(NL), .DIV_WIDTH(DW)) bus ();
    f1_light_seq_if #(.NUM_LIGHTS(2),  .DIV_WIDTH(DW)) bus2 ();
    f1_light_seq_if #(.NUM_LIGHTS(16), .DIV_WIDTH(DW)) bus16 ();

    f1_light_seq #(.NUM_LIGHTS(NL), .DIV_WIDTH(DW), .HOLD_TICKS(HT))
        dut (.clk(clk), .rst(rst), .bus(bus));
    f1_light_seq #(.NUM_LIGHTS(2), .DIV_WIDTH(DW), .HOLD_TICKS(HT))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    f1_light_seq #(.NUM_LIGHTS(16), .DIV_WIDTH(DW), .HOLD_TICKS(HT))
        dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: count enabled edges since the accept; the bar shows
    // floor(e/P) lights (P=N+1), full at NL*P, clear at (NL+H)*P.
    bit         m_act;
    bit         m_lo;
    int         m_e;
    int         m_p;
    int         m_h;
    logic [6:0] m_lfsr;

    always @(posedge clk) begin
        bit lo_n;
        lo_n = 1'b0;
        if (rst) begin
            m_act  = 1'b0;
            m_e    = 0;
            m_h    = 0;
            m_lfsr = 7'h01;
        end else if (bus.en) begin
            if (!m_act) begin
                if (bus.trigger) begin
                    m_act = 1'b1;
                    m_e   = 0;
                    m_p   = int'(bus.N) + 1;
                end
            end else begin
                m_e++;
                if (m_e == NL * m_p) begin
`ifdef RANDOM_DELAY_EN
                    m_h = int'(m_lfsr);
`else
                    m_h = HT;
`endif
                end
                if (m_e == (NL + m_h) * m_p) begin
                    m_act = 1'b0;
                    lo_n  = 1'b1;
                end
            end
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
        m_lo = lo_n;
    end

    function automatic logic [31:0] exp_bar();
        int k;
        if (!m_act) return 32'd0;
        k = m_e / m_p;
        if (k > NL) k = NL;
        return 32'((64'd1 << k) - 64'd1);
    endfunction

    function automatic int exp_hold();
`ifdef RANDOM_DELAY_EN
        return m_h;
`else
        return HT;
`endif
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("bar", 32'(bus.data_out), exp_bar());
            chk("busy", 32'(bus.busy), 32'(m_act));
            chk("lights_out", 32'(bus.lights_out),
                32'(m_lo & bus.en));
        end
    end

    task automatic run_seq(input int nv, input int st_at,
                           input int st_len, input bit poke,
                           output int t1, output int tf,
                           output int tc, output int nlo);
        bus.N = DW'(nv);
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        t1 = -1; tf = -1; tc = -1; nlo = 0;
        for (int i = 1; i <= 1000 && tc < 0; i++) begin
            bus.en = !(st_len > 0 && i > st_at &&
                       i <= st_at + st_len);
            bus.trigger = poke && (i == 3 || i == 10);
            step();
            if (bus.lights_out) nlo++;
            if (t1 < 0 && bus.data_out != '0) t1 = i;
            if (tf < 0 && &bus.data_out) tf = i;
            if (tc < 0 && !bus.busy) tc = i;
        end
        bus.en = 1'b1;
        bus.trigger = 1'b0;
        if (tc < 0) chk("seq_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill_tab [8];
        int t1, tf, tc, nlo, h;
        int f2, f16, c2, c16, xs;
        fill_tab = '{8'h01, 8'h03, 8'h07, 8'h0F,
                     8'h1F, 8'h3F, 8'h7F, 8'hFF};
        total = 0;
        bad = 0;
        chk_on = 1'b0;
        rst = 1'b1;
        bus.en = 1'b1;   bus.trigger = 1'b0;   bus.N = '0;
        bus2.en = 1'b1;  bus2.trigger = 1'b0;  bus2.N = '0;
        bus16.en = 1'b1; bus16.trigger = 1'b0; bus16.N = '0;
        step();
        step();
        chk_on = 1'b1;
        rst = 1'b0;

        // idle with trigger low
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_bar", 32'(bus.data_out), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_lo", 32'(bus.lights_out), 32'd0);
        end

        // basic fill, N=0
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        chk("acc_bar", 32'(bus.data_out), 32'd0);
        chk("acc_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("fill_bar", 32'(bus.data_out), 32'(fill_tab[i-1]));
            chk("fill_busy", 32'(bus.busy), 32'd1);
        end
`ifndef RANDOM_DELAY_EN
        for (int i = 9; i <= 13; i++) begin
            step();
            chk("hold_bar", 32'(bus.data_out),
                (i < 12) ? 32'hFF : 32'h0);
            chk("hold_busy", 32'(bus.busy), 32'(i < 12));
            chk("hold_lo", 32'(bus.lights_out), 32'(i == 12));
        end
`else
        for (int i = 0; i < 200 && bus.busy; i++) step();
        chk("rnd_idle", 32'(bus.busy), 32'd0);
`endif
        step();

        // prescaled N=3
        run_seq(3, 0, 0, 1'b0, t1, tf, tc, nlo);
        h = exp_hold();
        chk("n3_first", 32'(t1), 32'd4);
        chk("n3_full", 32'(tf), 32'd32);
        chk("n3_hold", 32'(tc - tf), 32'(h * 4));
        chk("n3_pulses", 32'(nlo), 32'd1);
`ifndef RANDOM_DELAY_EN
        chk("n3_hold_lit", 32'(tc - tf), 32'd16);
`endif

        // prescaled with a 5-cycle stall mid-fill
        run_seq(3, 10, 5, 1'b0, t1, tf, tc, nlo);
        h = exp_hold();
        chk("stall_first", 32'(t1), 32'd4);
        chk("stall_full", 32'(tf), 32'd37);
        chk("stall_hold", 32'(tc - tf), 32'(h * 4));
        chk("stall_pulses", 32'(nlo), 32'd1);

        // trigger pokes during FILL/HOLD are ignored
        run_seq(0, 0, 0, 1'b1, t1, tf, tc, nlo);
        h = exp_hold();
        chk("poke_first", 32'(t1), 32'd1);
        chk("poke_full", 32'(tf), 32'd8);
        chk("poke_clear", 32'(tc), 32'(8 + h));
        chk("poke_pulses", 32'(nlo), 32'd1);

        // reset abort at bar=0x07
        step();
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        step(); step(); step();
        chk("abort_pre", 32'(bus.data_out), 32'h07);
        rst = 1'b1;
        step();
        chk("abort_bar", 32'(bus.data_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_lo", 32'(bus.lights_out), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_quiet", 32'(bus.lights_out), 32'd0);
        end

        // 20 sequences: hold length and range
        for (int s = 0; s < 20; s++) begin
            repeat (s % 3 + 1) step();
            run_seq(0, 0, 0, 1'b0, t1, tf, tc, nlo);
            h = exp_hold();
            chk("seq_hold", 32'(tc - tf), 32'(h));
            chk("seq_range", 32'(tc - tf >= 1 && tc - tf <= 127),
                32'd1);
        end

        // generic widths 2 and 16
        step();
        bus2.trigger = 1'b1;
        bus16.trigger = 1'b1;
        step();
        bus2.trigger = 1'b0;
        bus16.trigger = 1'b0;
        f2 = -1; f16 = -1; c2 = -1; c16 = -1; xs = 0;
        for (int i = 1; i <= 400 && (c2 < 0 || c16 < 0); i++) begin
            step();
            if ($isunknown(bus2.data_out)) xs++;
            if ($isunknown(bus16.data_out)) xs++;
            if (f2 < 0 && &bus2.data_out) f2 = i;
            if (f16 < 0 && &bus16.data_out) f16 = i;
            if (c2 < 0 && !bus2.busy) c2 = i;
            if (c16 < 0 && !bus16.busy) c16 = i;
        end
        chk("w2_full", 32'(f2), 32'd2);
        chk("w16_full", 32'(f16), 32'd16);
        chk("w_no_x", 32'(xs), 32'd0);
        chk("w2_done", 32'(c2 > f2), 32'd1);
        chk("w16_done", 32'(c16 > f16), 32'd1);
`ifndef RANDOM_DELAY_EN
        chk("w2_clear", 32'(c2), 32'(2 + HT));
        chk("w16_clear", 32'(c16), 32'(16 + HT));
`endif
        step();
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
